// File: rtl/apb_stall_ctrl.sv
// Stalls the single-cycle core while a peripheral load/store runs a full APB
// SETUP/ACCESS transfer, then releases stop for exactly one DONE cycle.
module apb_stall_ctrl #(
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter int unsigned SLAVE_SHIFT = 12,
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           ALUResult,
    input  logic [31:0]           WriteData,
    output logic                  stop,
    output logic [31:0]           ReadData,
    output logic                  bus_err,
    output logic [31:0]           PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    localparam logic [NUM_SLAVES-1:0] SelOne   = NUM_SLAVES'(1);
    localparam logic [7:0]            LastWait = 8'(TIMEOUT - 1);

    state_e     state;
    logic [7:0] wait_cnt;
    logic       region_hit;
    logic       req;
    logic       decode_err;
    logic [3:0] idx;

    assign region_hit = (ALUResult[31:28] == PERIPH_BASE[31:28]);
    assign req        = (MemRead | MemWrite) & region_hit;
    assign idx        = ALUResult[SLAVE_SHIFT +: 4];
    assign decode_err = (32'(idx) >= NUM_SLAVES);

    // Only combinational output: the core must hold in the very cycle the request appears.
    assign stop = (state == StIdle && req) || (state == StSetup) || (state == StAccess);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            wait_cnt <= 8'd0;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= 32'd0;
            PWDATA   <= 32'd0;
            ReadData <= 32'd0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req) begin
                        PADDR    <= ALUResult;
                        PWDATA   <= WriteData;
                        PWRITE   <= MemWrite;
                        wait_cnt <= 8'd0;
                        if (decode_err) begin
                            ReadData <= 32'd0;
                            bus_err  <= 1'b1;
                            state    <= StDone;
                        end else begin
                            PSEL  <= SelOne << idx;
                            state <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    PENABLE <= 1'b1;
                    state   <= StAccess;
                end
                StAccess: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (PREADY) begin
                        if (!PWRITE) ReadData <= PRDATA;
                        bus_err <= PSLVERR;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= StDone;
                    end else if (wait_cnt == LastWait) begin
                        if (!PWRITE) ReadData <= 32'hDEAD_BEEF;
                        bus_err <= 1'b1;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    // Same instruction is still presented here, so never accept it again.
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_stall_ctrl.sv
// Bench for apb_stall_ctrl: a transaction-level model predicts every cycle of each
// instruction's occupancy; the core advances only when the model says stop is low.
module tb_apb_stall_ctrl;

    localparam int NS = 4;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'd0, WriteData = 32'd0;
    logic        stop;
    logic [31:0] ReadData;
    logic        bus_err;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE;
    logic [NS-1:0] PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA = 32'd0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;

    apb_stall_ctrl #(
        .PERIPH_BASE(32'h4000_0000),
        .SLAVE_SHIFT(12),
        .NUM_SLAVES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .stop     (stop),
        .ReadData (ReadData),
        .bus_err  (bus_err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en   = 1'b0;
    bit pend_rst = 1'b0;

    // Model expectations for the current cycle.
    logic        e_stop = 1'b0, e_pen = 1'b0, e_err = 1'b0, e_pwrite = 1'b0;
    logic [3:0]  e_psel = 4'd0;
    logic [31:0] e_paddr = 32'd0, e_pwdata = 32'd0, e_rdata = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stop",     32'(stop),     32'(e_stop));
            chk("psel",     32'(PSEL),     32'(e_psel));
            chk("penable",  32'(PENABLE),  32'(e_pen));
            chk("pwrite",   32'(PWRITE),   32'(e_pwrite));
            chk("paddr",    PADDR,         e_paddr);
            chk("pwdata",   PWDATA,        e_pwdata);
            chk("readdata", ReadData,      e_rdata);
            chk("bus_err",  32'(bus_err),  32'(e_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
    endtask

    // One instruction from first presentation to retirement. The slave raises PREADY
    // in ACCESS cycle w; rst_at >= 0 asserts reset in that ACCESS cycle instead.
    task automatic run_instr(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int w, input logic serr,
                             input logic [31:0] rdat, input int rst_at, output int ncyc);
        logic req;
        int   idx;
        int   n;
        bit   tmo;
        bit   rdy;
        req = (rd | wr) && (addr[31:28] == 4'h4);
        idx = int'(addr[15:12]);
        step();
        ncyc = 1;
        if (pend_rst) begin
            rst      = 1'b0;
            pend_rst = 1'b0;
            e_paddr  = 32'd0;
            e_pwdata = 32'd0;
            e_pwrite = 1'b0;
            e_rdata  = 32'd0;
            chk("rst_psel",  32'(PSEL),    32'd0);
            chk("rst_pen",   32'(PENABLE), 32'd0);
            chk("rst_rdata", ReadData,     32'd0);
        end
        MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wdata;
        rand_bus();
        e_stop = req; e_psel = 4'd0; e_pen = 1'b0; e_err = 1'b0;
        if (!req) return;
        if (idx >= NS) begin
            step(); ncyc++; rand_bus();
            e_stop = 1'b0; e_err = 1'b1; e_rdata = 32'd0;
            e_paddr = addr; e_pwdata = wdata; e_pwrite = wr;
            return;
        end
        step(); ncyc++; rand_bus();
        e_psel = 4'(1 << idx); e_paddr = addr; e_pwdata = wdata; e_pwrite = wr;
        tmo = (w >= TO);
        n   = tmo ? TO : w + 1;
        for (int k = 0; k < n; k++) begin
            step(); ncyc++;
            e_pen   = 1'b1;
            rdy     = !tmo && (k == w);
            PREADY  = rdy;
            PRDATA  = rdy ? rdat : $urandom;
            PSLVERR = rdy ? serr : 1'($urandom);
            if (k == rst_at) begin
                PREADY   = 1'b0;
                rst      = 1'b1;
                pend_rst = 1'b1;
                return;
            end
        end
        step(); ncyc++; rand_bus();
        e_stop = 1'b0; e_psel = 4'd0; e_pen = 1'b0;
        e_err  = tmo | serr;
        if (!wr) e_rdata = tmo ? 32'hDEAD_BEEF : rdat;
    endtask

    initial begin
        int          nc;
        int          kind;
        logic        rd, wr;
        logic [31:0] addr;

        step();
        chk_en = 1'b1;
        chk("reset_rdata", ReadData,  32'd0);
        chk("reset_psel",  32'(PSEL), 32'd0);
        step();
        rst = 1'b0;

        // Zero-wait load from slave 1.
        run_instr(1, 0, 32'h4000_1004, 32'h0, 0, 0, 32'h1234_5678, -1, nc);
        #1;
        chk("load_cycles", nc, 4);
        chk("load_rdata",  ReadData, 32'h1234_5678);
        chk("load_stop",   32'(stop), 32'd0);
        chk("load_err",    32'(bus_err), 32'd0);

        // Store with two wait states: DONE at T+5.
        run_instr(0, 1, 32'h4000_0000, 32'hCAFE_F00D, 2, 0, 32'h0, -1, nc);
        chk("store_cycles", nc, 6);
        chk("store_pwrite", 32'(PWRITE), 32'd1);
        chk("store_pwdata", PWDATA, 32'hCAFE_F00D);
        chk("store_rdata",  ReadData, 32'h1234_5678);

        // RAM load never stalls.
        run_instr(1, 0, 32'h0000_0100, 32'h0, 0, 0, 32'h0, -1, nc);
        #1;
        chk("ram_cycles", nc, 1);
        chk("ram_stop",   32'(stop), 32'd0);

        // Decode error on slave index 7.
        run_instr(1, 0, 32'h4000_7000, 32'h0, 0, 0, 32'h0, -1, nc);
        chk("dec_cycles", nc, 2);
        chk("dec_err",    32'(bus_err), 32'd1);
        chk("dec_rdata",  ReadData, 32'd0);

        // Timeout.
        run_instr(1, 0, 32'h4000_2000, 32'h0, 10, 0, 32'h0, -1, nc);
        chk("tmo_cycles", nc, 7);
        chk("tmo_err",    32'(bus_err), 32'd1);
        chk("tmo_rdata",  ReadData, 32'hDEAD_BEEF);

        // Slave error, then a following RAM op shows the pulse has dropped.
        run_instr(1, 0, 32'h4000_3000, 32'h0, 1, 1, 32'h5555_AAAA, -1, nc);
        chk("slverr_err", 32'(bus_err), 32'd1);
        run_instr(0, 1, 32'h0000_0200, 32'h1, 0, 0, 32'h0, -1, nc);
        chk("slverr_pulse", 32'(bus_err), 32'd0);

        // Reset in the first ACCESS cycle, request still present afterwards.
        run_instr(1, 0, 32'h4000_2008, 32'h0, 3, 0, 32'h0, 0, nc);
        run_instr(1, 0, 32'h4000_2008, 32'h0, 0, 0, 32'h0BAD_F00D, -1, nc);
        chk("rst_retry_cycles", nc, 4);
        chk("rst_retry_rdata",  ReadData, 32'h0BAD_F00D);

        // Back-to-back peripheral loads.
        run_instr(1, 0, 32'h4000_1000, 32'h0, 0, 0, 32'h1111_1111, -1, nc);
        chk("b2b_first", nc, 4);
        run_instr(1, 0, 32'h4000_2000, 32'h0, 0, 0, 32'h2222_2222, -1, nc);
        chk("b2b_second", nc, 4);
        chk("b2b_rdata",  ReadData, 32'h2222_2222);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            rd   = 1'($urandom);
            wr   = 1'($urandom);
            addr = $urandom;
            if (kind < 7) addr[31:28] = 4'h4;
            if (kind < 6) addr[15:12] = 4'($urandom_range(0, NS - 1));
            run_instr(rd, wr, addr, $urandom, $urandom_range(0, 6), 1'($urandom), $urandom,
                      ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1, nc);
        end

        run_instr(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, -1, nc);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_stall_ctrl.md
# apb_stall_ctrl

Sequencer between the single-cycle RISC-V core and the APB peripheral bus. It detects a load or store to the peripheral region, runs a full APB SETUP/ACCESS transfer, and holds the core's `stop` line high so the PC adder repeats the current PC and the instruction re-executes until the transfer completes. It releases `stop` for exactly one completion cycle, with the read data registered, so the load or store retires once.

## Interface
- `PERIPH_BASE`, 32'h4000_0000: peripheral region base; a hit is `addr[31:28] == PERIPH_BASE[31:28]`.
- `SLAVE_SHIFT`, 12: LSB of the slave index field in the address.
- `NUM_SLAVES`, 4: number of PSEL lines (1..16).
- `TIMEOUT`, 255: maximum ACCESS cycles waiting for PREADY (1..255).

- `clk`  in  1  core/bus clock.
- `rst`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  current instruction is a load.
- `MemWrite`  in  1  current instruction is a store.
- `ALUResult`  in  32  effective address.
- `WriteData`  in  32  store data.
- `stop`  out  1  to PC adder and register-file write gating; high means hold the instruction.
- `ReadData`  out  32  registered APB read data, valid in the DONE cycle.
- `bus_err`  out  1  one-cycle pulse in DONE on PSLVERR, timeout or decode error.
- `PADDR`  out  32  APB address.
- `PWDATA`  out  32  APB write data.
- `PWRITE`  out  1  APB direction.
- `PSEL`  out  NUM_SLAVES  one-hot slave select.
- `PENABLE`  out  1  APB enable.
- `PRDATA`  in  32  muxed slave read data.
- `PREADY`  in  1  muxed slave ready.
- `PSLVERR`  in  1  muxed slave error.

## Operation
- `req = (MemRead | MemWrite) & region_hit`. If both MemRead and MemWrite are high, the access is a write.
- Slave index: `idx = ALUResult[SLAVE_SHIFT +: 4]`. `idx >= NUM_SLAVES` is a decode error.
- States:
  - IDLE: if `req` is high, latch the address, data and direction into PADDR/PWDATA/PWRITE. On a valid index, go to SETUP. On a decode error, go to DONE with the error flag set and ReadData = 0.
  - SETUP: PSEL[idx] = 1, PENABLE = 0. Go to ACCESS unconditionally.
  - ACCESS: PSEL[idx] = 1, PENABLE = 1, wait counter increments.
    - PREADY = 1: capture PRDATA (reads only; writes leave ReadData unchanged), capture PSLVERR into the error flag, go to DONE.
    - Counter reaches TIMEOUT with no PREADY: error flag = 1, ReadData = 32'hDEAD_BEEF for reads, go to DONE.
  - DONE: PSEL = 0, PENABLE = 0, `stop` = 0, `bus_err` = error flag. Always go to IDLE. No new request is accepted in DONE, because the same instruction is still presented.
- `stop` (combinational) = `(IDLE & req) | SETUP | ACCESS`. It is low in DONE and in IDLE with no request.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the final ACCESS cycle. They keep their last values in IDLE and DONE.
- Non-peripheral accesses never touch APB and never assert `stop`.
- Reset, including mid-transfer: state = IDLE, PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, ReadData = 0, bus_err = 0, counter = 0. The APB transfer is abandoned. If `req` is still high after reset, a fresh transfer starts.

## Timing
- Request detected in cycle T (IDLE, `stop` = 1), SETUP in T+1, first ACCESS in T+2.
- Zero-wait slave: DONE in T+3. The instruction retires at the T+3 edge, giving 4 cycles of occupancy.
- Each wait state adds one cycle.
- Timeout path: DONE occurs TIMEOUT cycles after the first ACCESS cycle.
- Decode error: DONE in T+1.
- Back-to-back peripheral instructions: the second instruction is seen in IDLE in the cycle after DONE, with no dead cycle beyond DONE.
- PSEL/PENABLE change only on clock edges (registered state decode). `stop` is the only output with a combinational path from inputs.

## Test plan
- Load from 32'h4000_1004 with a zero-wait slave 1 returning 32'h1234_5678:
  - PSEL = 4'b0010 in T+1 and T+2, PENABLE high only in T+2, `stop` high T..T+2.
  - ReadData = 32'h1234_5678 and `stop` = 0 in T+3, bus_err = 0.
- Store of 32'hCAFE_F00D to 32'h4000_0000 with PREADY delayed 3 cycles:
  - PWRITE = 1, PWDATA stable across ACCESS, DONE at T+5, `stop` high T..T+4.
- Load from 32'h0000_0100 (RAM): no PSEL, `stop` stays 0. Load from 32'h4000_7000 (idx 7 ≥ 4): no PSEL, DONE at T+1, bus_err pulse, ReadData = 0.
- PREADY held low with TIMEOUT = 4: bus_err = 1 and ReadData = 32'hDEAD_BEEF in DONE.
  - PREADY with PSLVERR = 1: bus_err = 1 for exactly one cycle.
- `rst` asserted during ACCESS: next cycle PSEL = 0, PENABLE = 0, ReadData = 0. With `req` still high after reset, a new SETUP follows.
- Two consecutive peripheral loads: each gets its own SETUP/ACCESS, and exactly one DONE cycle separates the two transfers.
